// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake; iterative multiply and optional restoring divide.
// Define ALU_MC_DIV_EN to build the divider (ops 15/16); otherwise those ops are illegal.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpSub  = 5'd1;
    localparam logic [4:0] OpSlt  = 5'd2;
    localparam logic [4:0] OpSltu = 5'd3;
    localparam logic [4:0] OpAnd  = 5'd4;
    localparam logic [4:0] OpNor  = 5'd5;
    localparam logic [4:0] OpOr   = 5'd6;
    localparam logic [4:0] OpXor  = 5'd7;
    localparam logic [4:0] OpSll  = 5'd8;
    localparam logic [4:0] OpSrl  = 5'd9;
    localparam logic [4:0] OpSra  = 5'd10;
    localparam logic [4:0] OpLui  = 5'd11;
    localparam logic [4:0] OpNand = 5'd12;
    localparam logic [4:0] OpMul  = 5'd13;
    localparam logic [4:0] OpMulu = 5'd14;
    localparam logic [4:0] OpDiv  = 5'd15;
    localparam logic [4:0] OpDivu = 5'd16;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             neg_q, neg_d;
`ifdef ALU_MC_DIV_EN
    logic             div_q, div_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    // Single-cycle results, computed straight from the request inputs
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] simple_hi;
    logic             simple_err;
    logic             long_op;

    assign shamt   = src1[SHW-1:0];
    assign sra_res = $signed(src2) >>> shamt;

    always_comb begin
        simple_res = '0;
        simple_hi  = '0;
        simple_err = 1'b0;
        long_op    = 1'b0;
        case (op)
            OpAdd:  simple_res = src1 + src2;
            OpSub:  simple_res = src1 - src2;
            OpSlt:  simple_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
            OpSltu: simple_res = {{(WIDTH-1){1'b0}}, src1 < src2};
            OpAnd:  simple_res = src1 & src2;
            OpNor:  simple_res = ~(src1 | src2);
            OpOr:   simple_res = src1 | src2;
            OpXor:  simple_res = src1 ^ src2;
            OpSll:  simple_res = src2 << shamt;
            OpSrl:  simple_res = src2 >> shamt;
            OpSra:  simple_res = sra_res;
            OpLui:  simple_res = {src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OpNand: simple_res = ~(src1 & src2);
            OpMul,
            OpMulu: long_op = 1'b1;
`ifdef ALU_MC_DIV_EN
            OpDiv,
            OpDivu: begin
                if (src2 == '0) begin
                    simple_res = '1;
                    simple_hi  = src1;
                    simple_err = 1'b1;
                end else begin
                    long_op = 1'b1;
                end
            end
`endif
            default: simple_err = 1'b1;
        endcase
    end

    // Iterate on magnitudes; the sign is reapplied once the last step completes
    logic             signed_op;
    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    assign signed_op = (op == OpMul) || (op == OpDiv);
    assign s1_neg    = signed_op & src1[WIDTH-1];
    assign s2_neg    = signed_op & src2[WIDTH-1];
    assign mag1      = s1_neg ? -src1 : src1;
    assign mag2      = s2_neg ? -src2 : src2;

    // Shift-add multiply: acc_lo holds the multiplier and fills with product bits
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);

`ifdef ALU_MC_DIV_EN
    // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out, quotient in
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opa_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opa_q;
`endif

    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        if (div_q) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;

    assign prod_mag = {step_hi, step_lo};
    assign prod     = neg_q ? -prod_mag : prod_mag;

    always_comb begin
        fin_lo = prod[WIDTH-1:0];
        fin_hi = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_DIV_EN
        if (div_q) begin
            fin_lo = neg_q ? -step_lo : step_lo;
            fin_hi = neg_rem_q ? -step_hi : step_hi;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        err_d       = err_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opa_d       = opa_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
`ifdef ALU_MC_DIV_EN
        div_d       = div_q;
        neg_rem_d   = neg_rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (long_op) begin
                        state_d  = StCalc;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        acc_lo_d = mag2;
                        opa_d    = mag1;
                        neg_d    = s1_neg ^ s2_neg;
`ifdef ALU_MC_DIV_EN
                        div_d     = (op == OpDiv) || (op == OpDivu);
                        neg_rem_d = s1_neg;
                        if (div_d) begin
                            acc_lo_d = mag1;
                            opa_d    = mag2;
                        end
`endif
                    end else begin
                        state_d     = StDone;
                        result_d    = simple_res;
                        result_hi_d = simple_hi;
                        err_d       = simple_err;
                    end
                end
            end
            StCalc: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StDone;
                    result_d    = fin_lo;
                    result_hi_d = fin_hi;
                    err_d       = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            result_q    <= '0;
            result_hi_q <= '0;
            err_q       <= 1'b0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opa_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            err_q       <= err_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opa_q       <= opa_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
`ifdef ALU_MC_DIV_EN
            div_q       <= div_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    // Gated by resetn so the requester never sees ready while reset is held
    assign in_ready  = (state_q == StIdle) && resetn;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32); DIV expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_res,
                          input logic [31:0] e_hi, input logic e_err, input int e_lat);
        int guard;
        int lat;
        in_valid = 1'b1;
        op       = o;
        src1     = a;
        src2     = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
        op       = 5'($urandom_range(0, 31));
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, 64'(lat), 64'(e_lat));
        check({tag, ":result"}, 64'(result), 64'(e_res));
        check({tag, ":result_hi"}, 64'(result_hi), 64'(e_hi));
        check({tag, ":err"}, 64'(err), 64'(e_err));
        check({tag, ":busy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst:in_ready", 64'(in_ready), 64'd0);
        check("rst:out_valid", 64'(out_valid), 64'd0);
        check("rst:result", 64'(result), 64'd0);
        check("rst:result_hi", 64'(result_hi), 64'd0);
        check("rst:err", 64'(err), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 1'b0, 1);
        run_op("sub",     5'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'h0, 1'b0, 1);
        run_op("slt",     5'd2, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0, 1);
        run_op("sltu_lt", 5'd3, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
        run_op("sltu_ge", 5'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1);
        run_op("and",     5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 1'b0, 1);
        run_op("nor",     5'd5, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 32'h0, 1'b0, 1);
        run_op("or",      5'd6, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'h0, 1'b0, 1);
        run_op("xor",     5'd7, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 32'h0, 1'b0, 1);
        run_op("sll",     5'd8, 32'h24, 32'h1, 32'h10, 32'h0, 1'b0, 1);
        run_op("srl",     5'd9, 32'h4, 32'h8000_0000, 32'h0800_0000, 32'h0, 1'b0, 1);
        run_op("sra",     5'd10, 32'h4, 32'h8000_0000, 32'hF800_0000, 32'h0, 1'b0, 1);
        run_op("sra_pos", 5'd10, 32'd31, 32'h4000_0000, 32'h0, 32'h0, 1'b0, 1);
        run_op("lui",     5'd11, 32'h0, 32'h1234_ABCD, 32'hABCD_0000, 32'h0, 1'b0, 1);
        run_op("nand",    5'd12, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_FFFF, 32'h0, 1'b0, 1);
        run_op("mul_neg", 5'd13, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("mul_min", 5'd13, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1'b0, 33);
        run_op("mulu_max", 5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("mulu_16", 5'd14, 32'h1_0000, 32'h1_0000, 32'h0, 32'h1, 1'b0, 33);
        run_op("illegal17", 5'd17, 32'h5, 32'h6, 32'h0, 32'h0, 1'b1, 1);
        run_op("illegal31", 5'd31, 32'h5, 32'h6, 32'h0, 32'h0, 1'b1, 1);

        // Hold the result under back-pressure while a new request waits
        in_valid = 1'b1;
        op       = 5'd0;
        src1     = 32'd10;
        src2     = 32'd20;
        @(posedge clk); #1;
        op   = 5'd1;
        src1 = 32'd100;
        src2 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            check("hold:out_valid", 64'(out_valid), 64'd1);
            check("hold:result", 64'(result), 64'd30);
            check("hold:in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        check("hold:result_end", 64'(result), 64'd30);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b:in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b:out_valid", 64'(out_valid), 64'd1);
        check("b2b:result", 64'(result), 64'd99);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply
        in_valid = 1'b1;
        op       = 5'd13;
        src1     = 32'd7;
        src2     = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("abort:out_valid", 64'(out_valid), 64'd0);
        check("abort:in_ready", 64'(in_ready), 64'd0);
        check("abort:result", 64'(result), 64'd0);
        check("abort:result_hi", 64'(result_hi), 64'd0);
        check("abort:err", 64'(err), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort:no_result", 64'(out_valid), 64'd0);
        run_op("add_after", 5'd0, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1);

`ifdef ALU_MC_DIV_EN
        run_op("div_neg",  5'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("div_rpos", 5'd15, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 33);
        run_op("divu_z",   5'd16, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'h9, 1'b1, 1);
        run_op("div_min",  5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);
        run_op("divu",     5'd16, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
`else
        run_op("div_off",  5'd15, 32'd6, 32'd3, 32'h0, 32'h0, 1'b1, 1);
        run_op("divu_off", 5'd16, 32'd9, 32'd0, 32'h0, 32'h0, 1'b1, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
